regfile_dumper: RTL and testbench
=================================

REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0: first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31: last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 SHALL have port r_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clk_enable  input  1  when low, all state and outputs hold.
REQ-006 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-007 SHALL have port read_reg  output  5  register-file read address.
REQ-008 SHALL have port read_data  input  32  combinational register-file read data for read_reg.
REQ-009 SHALL have port dump_valid  output  1  dump_index/dump_data are valid.
REQ-010 SHALL have port dump_ready  input  1  consumer accepts the current word.
REQ-011 SHALL have port dump_index  output  5  register index of the offered word.
REQ-012 SHALL have port dump_data  output  32  captured register value.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last word is accepted.
REQ-015 SHALL have port checksum  output  32  XOR of all words accepted in the current or most recent dump.

Function
REQ-016 SHALL implement states IDLE, FETCH, OFFER and FINISH.
REQ-017 In IDLE, start=1 SHALL load the index counter with FIRST_REG, clear checksum and enter FETCH.
REQ-018 read_reg SHALL always equal the index counter.
REQ-019 In FETCH, the block SHALL capture read_data into dump_data and the counter into dump_index, then enter OFFER.
REQ-020 In OFFER, dump_valid SHALL be 1, and dump_data/dump_index SHALL stay stable until the handshake.
REQ-021 A handshake (dump_valid and dump_ready high on one edge) SHALL XOR dump_data into checksum.
REQ-022 On handshake with counter < LAST_REG, the block SHALL increment the counter and enter FETCH.
REQ-023 On handshake with counter == LAST_REG, the block SHALL enter FINISH and SHALL NOT increment the counter (no wrap).
REQ-024 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Each word SHALL take at least 2 cycles (FETCH + OFFER); a full dump with dump_ready held high SHALL take 2*(LAST_REG-FIRST_REG+1)+1 cycles from the start edge to the done pulse.
REQ-026 start SHALL be ignored outside IDLE; start in the cycle done is high SHALL be ignored.
REQ-027 When FIRST_REG == LAST_REG, the block SHALL emit exactly one word, then done.
REQ-028 When clk_enable=0, no transition, capture or checksum update SHALL occur, even if dump_ready=1.
REQ-029 Register 0 SHALL be dumped as whatever read_data returns, with no special-casing.
REQ-030 checksum SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-031 reset SHALL force IDLE immediately and asynchronously, including mid-dump.
REQ-032 On reset: counter=FIRST_REG, dump_valid=0, dump_index=0, dump_data=0, checksum=0, busy=0, done=0.
REQ-033 After reset release, no word SHALL be offered until a new start.

Structure
REQ-034 The state enum type and the width constants (5-bit index, 32-bit word) SHALL live in shared package mips_dump_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the checksum SHALL be inline.

Verification
REQ-036 Regfile loaded with reg[i]=i*0x01010101, start pulse, dump_ready=1 -> 32 words, indices 0..31, done after 65 cycles, checksum = XOR of all values.
REQ-037 Same load, dump_ready toggling 1-0-1 each cycle -> word stable while dump_ready=0, no duplicate or lost index, same checksum.
REQ-038 FIRST_REG=LAST_REG=2, reg[2]=0xDEADBEEF -> one word {2, 0xDEADBEEF}, checksum=0xDEADBEEF, done once.
REQ-039 reset asserted during OFFER of index 10 -> dump_valid falls without a clock edge, busy=0, and the next start restarts at index 0.
REQ-040 clk_enable=0 for 5 cycles during OFFER with dump_ready=1 -> no handshake, and the dump resumes correctly once clk_enable returns high.
REQ-041 start held high during and after a dump -> the second dump begins only from IDLE, never in the done cycle.

Source files
------------

// File: rtl/mips_dump_pkg.sv
// Shared types and widths for the register-file dump engine.
package mips_dump_pkg;

  localparam int IDX_W  = 5;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_OFFER,
    ST_FINISH
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Bundle of the dump engine's start, register-file read and word-stream signals.
interface regfile_dumper_if;
  import mips_dump_pkg::*;

  logic              start;
  logic [IDX_W-1:0]  read_reg;
  logic [WORD_W-1:0] read_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_index;
  logic [WORD_W-1:0] dump_data;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] checksum;

  // master is the dump engine; slave is the register file plus word consumer
  modport master (
    input  start, read_data, dump_ready,
    output read_reg, dump_valid, dump_index, dump_data, busy, done, checksum
  );

  modport slave (
    output start, read_data, dump_ready,
    input  read_reg, dump_valid, dump_index, dump_data, busy, done, checksum
  );

endinterface

// File: rtl/regfile_dumper.sv
// Walks register indices FIRST_REG..LAST_REG, offering each value on a
// valid/ready stream and folding every accepted word into an XOR checksum.
module regfile_dumper
  import mips_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              r_clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              start,
  output logic [IDX_W-1:0]  read_reg,
  input  logic [WORD_W-1:0] read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_index,
  output logic [WORD_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  dump_state_t       state, state_next;
  logic [IDX_W-1:0]  counter;
  logic              load, capture, accept, advance;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        capture    = 1'b1;
        state_next = ST_OFFER;
      end
      ST_OFFER: begin
        if (dump_ready) begin
          accept = 1'b1;
          // the last index finishes without wrapping the counter
          if (counter == LAST_IDX) begin
            state_next = ST_FINISH;
          end else begin
            advance    = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      counter    <= FIRST_IDX;
      dump_index <= '0;
      dump_data  <= '0;
      checksum   <= '0;
    end else if (clk_enable) begin
      state <= state_next;
      if (load) begin
        counter  <= FIRST_IDX;
        checksum <= '0;
      end
      if (advance) counter <= counter + 1'b1;
      if (capture) begin
        dump_index <= counter;
        dump_data  <= read_data;
      end
      if (accept) checksum <= checksum ^ dump_data;
    end
  end

  assign read_reg   = counter;
  assign dump_valid = (state == ST_OFFER);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_FINISH);

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench: a behavioural register-file model, randomized and
// directed dump runs, and a scoreboard of expected indices, words and checksums.
module tb_regfile_dumper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_enable = 1'b1;

  logic [31:0] regs  [32];
  logic [31:0] regs2 [32];

  int checks = 0;
  int errors = 0;

  regfile_dumper_if bus ();
  regfile_dumper_if bus2 ();

  assign bus.read_data  = regs[bus.read_reg];
  assign bus2.read_data = regs2[bus2.read_reg];

  always #5 clk = ~clk;

  regfile_dumper #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .r_clk(clk), .reset(rst), .clk_enable(clk_enable), .start(bus.start),
    .read_reg(bus.read_reg), .read_data(bus.read_data),
    .dump_valid(bus.dump_valid), .dump_ready(bus.dump_ready),
    .dump_index(bus.dump_index), .dump_data(bus.dump_data),
    .busy(bus.busy), .done(bus.done), .checksum(bus.checksum)
  );

  regfile_dumper #(.FIRST_REG(2), .LAST_REG(2)) dut2 (
    .r_clk(clk), .reset(rst), .clk_enable(clk_enable), .start(bus2.start),
    .read_reg(bus2.read_reg), .read_data(bus2.read_data),
    .dump_valid(bus2.dump_valid), .dump_ready(bus2.dump_ready),
    .dump_index(bus2.dump_index), .dump_data(bus2.dump_data),
    .busy(bus2.busy), .done(bus2.done), .checksum(bus2.checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xor_all();
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) acc ^= regs[i];
    return acc;
  endfunction

  // mode 0: ready always high, 1: ready toggles every cycle, 2: random ready.
  // stall_idx >= 0 drops clk_enable for 5 cycles while that index is offered.
  task automatic run_dump(input int mode, input int stall_idx, input bit hold_start);
    int          exp_idx = 0;
    logic [31:0] exp_sum = '0;
    int          cycles = 0;
    bit          seen_done = 0;
    bit          stalled = 0;
    bit          tog = 1;
    bit          pending = 0;
    bit          ready;
    logic [4:0]  prev_idx = '0;
    logic [31:0] prev_data = '0;
    logic [31:0] held_sum;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.dump_ready = 1'b0;
    for (int c = 0; c < 600 && !seen_done; c++) begin
      @(negedge clk);
      cycles++;
      if (!hold_start) bus.start = 1'b0;
      if (bus.done) begin
        seen_done = 1;
      end else if (bus.dump_valid) begin
        if (pending) begin
          check("stable_index", bus.dump_index, prev_idx);
          check("stable_data", bus.dump_data, prev_data);
        end
        if (!stalled && int'(bus.dump_index) == stall_idx) begin
          stalled  = 1;
          held_sum = bus.checksum;
          prev_idx = bus.dump_index;
          prev_data = bus.dump_data;
          clk_enable     = 1'b0;
          bus.dump_ready = 1'b1;
          repeat (5) begin
            @(negedge clk);
            check("stall_valid", bus.dump_valid, 1);
            check("stall_index", bus.dump_index, prev_idx);
            check("stall_data", bus.dump_data, prev_data);
            check("stall_checksum", bus.checksum, held_sum);
          end
          clk_enable = 1'b1;
        end
        case (mode)
          0:       ready = 1'b1;
          1:       ready = tog;
          default: ready = ($urandom_range(0, 3) != 0);
        endcase
        bus.dump_ready = ready;
        if (ready) begin
          if (exp_idx > 31) begin
            check("no_extra_word", bus.dump_valid, 0);
          end else begin
            check("word_index", bus.dump_index, exp_idx);
            check("word_data", bus.dump_data, regs[exp_idx]);
            exp_sum ^= regs[exp_idx];
          end
          exp_idx++;
          pending = 0;
        end else begin
          pending   = 1;
          prev_idx  = bus.dump_index;
          prev_data = bus.dump_data;
        end
      end else begin
        check("fetch_read_reg", bus.read_reg, exp_idx);
        check("fetch_busy", bus.busy, 1);
        bus.dump_ready = (mode == 1) ? tog : 1'b0;
      end
      tog = !tog;
    end
    check("done_seen", seen_done, 1);
    check("word_count", exp_idx, 32);
    check("checksum_final", bus.checksum, exp_sum);
    check("checksum_vs_regs", exp_sum, xor_all());
    if (stall_idx < 0 && mode == 0) check("dump_cycles", cycles, 65);

    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
    check("checksum_hold", bus.checksum, exp_sum);
    if (hold_start) begin
      @(negedge clk);
      check("restart_busy", bus.busy, 1);
      check("restart_fetch", bus.dump_valid, 0);
      check("restart_index", bus.read_reg, 0);
      check("restart_clear", bus.checksum, 0);
      bus.start      = 1'b0;
      bus.dump_ready = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
        @(negedge clk);
        if (bus.done) seen_done = 1;
      end
      check("second_done", seen_done, 1);
      check("second_checksum", bus.checksum, exp_sum);
      @(negedge clk);
    end else begin
      @(negedge clk);
      check("stay_idle", bus.busy, 0);
    end
    bus.dump_ready = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int          words;
    int          dones;
    logic [4:0]  got_idx;
    logic [31:0] got_data;

    bus.start = 1'b0;  bus.dump_ready = 1'b0;
    bus2.start = 1'b0; bus2.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs[i]  = i * 32'h0101_0101;
      regs2[i] = $urandom;
    end
    regs2[2] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    check("rst_valid", bus.dump_valid, 0);
    check("rst_index", bus.dump_index, 0);
    check("rst_data", bus.dump_data, 0);
    check("rst_checksum", bus.checksum, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_read_reg", bus.read_reg, 0);
    check("rst_read_reg2", bus2.read_reg, 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_offer", bus.dump_valid, 0);

    run_dump(0, -1, 0);
    run_dump(1, -1, 0);
    run_dump(0, 7, 0);

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    run_dump(2, -1, 0);
    run_dump(2, $urandom_range(0, 31), 0);

    // asynchronous reset while index 10 is on offer
    @(negedge clk);
    bus.start = 1'b1;
    bus.dump_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (bus.dump_valid && bus.dump_index == 5'd10) found = 1;
      else @(negedge clk);
    end
    check("reach_index10", found, 1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", bus.dump_valid, 0);
    check("async_busy", bus.busy, 0);
    check("async_checksum", bus.checksum, 0);
    check("async_read_reg", bus.read_reg, 0);
    check("async_index", bus.dump_index, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_offer", bus.dump_valid, 0);
    check("post_rst_idle", bus.busy, 0);
    run_dump(0, -1, 0);

    run_dump(0, -1, 1);

    // single-register instance
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.dump_ready = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    words = 0; dones = 0; got_idx = '0; got_data = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus2.dump_valid) begin
        words++;
        got_idx  = bus2.dump_index;
        got_data = bus2.dump_data;
      end
      if (bus2.done) dones++;
      @(negedge clk);
    end
    check("single_words", words, 1);
    check("single_index", got_idx, 2);
    check("single_data", got_data, 32'hDEAD_BEEF);
    check("single_checksum", bus2.checksum, 32'hDEAD_BEEF);
    check("single_done", dones, 1);
    check("single_idle", bus2.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
